// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_arb_pkg
//  Description : Shared constants for the divider arbiter. Holds the FSM state
//                encoding, the default widths and the divider status flag codes
//                in priority order (dvz > ovf > valid).
//  Revision    : 1.0 - initial release
// ============================================================================
package div_arb_pkg;

    parameter int W_DEF = 10;
    parameter int N_DEF = 4;

    // FSM state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    // Divider status codes, resolved in priority order
    localparam logic [1:0] c_flg_none  = 2'd0;
    localparam logic [1:0] c_flg_dvz   = 2'd1;
    localparam logic [1:0] c_flg_ovf   = 2'd2;
    localparam logic [1:0] c_flg_valid = 2'd3;

    // Reduce simultaneous divider status pulses to the single winning flag.
    function automatic logic [1:0] flag_pick(input logic dvz,
                                             input logic ovf,
                                             input logic vld);
        if (dvz)      return c_flg_dvz;
        else if (ovf) return c_flg_ovf;
        else if (vld) return c_flg_valid;
        else          return c_flg_none;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Picks the first asserted
//                request at or after ptr, wrapping to index 0.
//  Ports       : req   [N]   request vector
//                ptr   [IDW] search start index
//                grant [N]   one-hot winner (zero when no request)
//                idx   [IDW] binary index of the winner
//                any         at least one request asserted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import div_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [N-1:0] w_hi_mask;
    logic [N-1:0] w_hi_req;
    logic [N-1:0] w_pick_src;

    // Requests at or above the pointer have first claim; if none exist the
    // search wraps and the lowest asserted index overall wins.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign w_hi_mask[gi] = (IDW'(gi) >= ptr);
    end

    assign w_hi_req   = req & w_hi_mask;
    assign w_pick_src = (|w_hi_req) ? w_hi_req : req;
    // Isolate the lowest set bit
    assign grant      = w_pick_src & (~w_pick_src + N'(1));
    assign any        = |req;

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                idx = idx | IDW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : divider_arbiter
//  Description : Shares one sequential divider between N requesters using
//                round-robin arbitration. Latches the winner's operands, pulses
//                the divider start, waits for a divider status pulse and
//                returns quotient / remainder / flags to the winner.
//  Ports       : clock, sclr                 clock and synchronous reset
//                req, req_a, req_b          requester side (packed slices)
//                gnt                        one-hot accept pulse
//                rsp_valid, rsp_id, rsp_q, rsp_r, rsp_ovf, rsp_dvz, rsp_tmo
//                                           response (fields held until next)
//                busy                       state != IDLE
//                div_start, div_sclr, div_a, div_b      to divider
//                div_busy, div_valid, div_ovf, div_dvz, div_q, div_r
//                                           from divider
//  Options     : DIV_ARB_WATCHDOG_EN - abort a WAIT lasting TMO_CYC cycles,
//                clearing the divider and answering with rsp_tmo=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 64
) (
    input  logic           clock,
    input  logic           sclr,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   gnt,
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output logic [W-1:0]   rsp_q,
    output logic [W-1:0]   rsp_r,
    output logic           rsp_ovf,
    output logic           rsp_dvz,
    output logic           rsp_tmo,
    output logic           busy,
    output logic           div_start,
    output logic           div_sclr,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic           div_busy,
    input  logic           div_valid,
    input  logic           div_ovf,
    input  logic           div_dvz,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r
);

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [N-1:0]   r_gnt;
    logic           r_div_start;
    logic [W-1:0]   r_div_a;
    logic [W-1:0]   r_div_b;
    logic [W-1:0]   r_rsp_q;
    logic [W-1:0]   r_rsp_r;
    logic           r_rsp_ovf;
    logic           r_rsp_dvz;

    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [1:0]     w_flag;
    logic           w_status;
    logic           w_tmo_hit;

    // The handshake relies solely on the status pulses; busy is not needed.
    logic           w_unused;
    assign w_unused = div_busy;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    // One-hot AND-OR operand mux
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_sel_a = w_sel_a | req_a[i*W +: W];
                w_sel_b = w_sel_b | req_b[i*W +: W];
            end
        end
    end

    // Status only matters while waiting on the divider
    assign w_flag   = (r_state == c_st_wait) ? flag_pick(div_dvz, div_ovf, div_valid)
                                             : c_flg_none;
    assign w_status = (w_flag != c_flg_none);

`ifdef DIV_ARB_WATCHDOG_EN
    localparam int c_wd_w = $clog2(TMO_CYC) + 1;

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_rsp_tmo;

    // Counts WAIT cycles; zero on the first WAIT cycle
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_st_issue) begin
            r_wd_cnt <= '0;
        end else if (r_state == c_st_wait) begin
            r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
        end
    end

    // A status landing on the timeout cycle takes precedence
    assign w_tmo_hit = (r_state == c_st_wait) && !w_status &&
                       (r_wd_cnt == c_wd_w'(TMO_CYC - 1));

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_rsp_tmo <= 1'b0;
        end else if (w_status) begin
            r_rsp_tmo <= 1'b0;
        end else if (w_tmo_hit) begin
            r_rsp_tmo <= 1'b1;
        end
    end

    assign rsp_tmo = r_rsp_tmo;
`else
    assign w_tmo_hit = 1'b0;
    assign rsp_tmo   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_any) w_state_nxt = c_st_issue;
            c_st_issue: w_state_nxt = c_st_wait;
            c_st_wait:  if (w_status || w_tmo_hit) w_state_nxt = c_st_resp;
            c_st_resp:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand latch, response capture, pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sclr) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_div_start <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_dvz   <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_div_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_gnt   <= w_grant;
                        r_id    <= w_idx;
                        r_div_a <= w_sel_a;
                        r_div_b <= w_sel_b;
                    end
                end
                c_st_issue: begin
                    // Registered so the start pulse trails gnt by one cycle
                    r_div_start <= 1'b1;
                end
                c_st_wait: begin
                    case (w_flag)
                        c_flg_dvz: begin
                            r_rsp_q   <= '0;
                            r_rsp_r   <= '0;
                            r_rsp_ovf <= 1'b0;
                            r_rsp_dvz <= 1'b1;
                        end
                        c_flg_ovf: begin
                            r_rsp_q   <= div_q;
                            r_rsp_r   <= div_r;
                            r_rsp_ovf <= 1'b1;
                            r_rsp_dvz <= 1'b0;
                        end
                        c_flg_valid: begin
                            r_rsp_q   <= div_q;
                            r_rsp_r   <= div_r;
                            r_rsp_ovf <= 1'b0;
                            r_rsp_dvz <= 1'b0;
                        end
                        default: begin
                            if (w_tmo_hit) begin
                                r_rsp_q   <= '0;
                                r_rsp_r   <= '0;
                                r_rsp_ovf <= 1'b0;
                                r_rsp_dvz <= 1'b0;
                            end
                        end
                    endcase
                end
                c_st_resp: begin
                    r_ptr <= (r_id == IDW'(N - 1)) ? '0 : r_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign div_start = r_div_start;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign div_sclr  = sclr | w_tmo_hit;
    assign rsp_valid = (r_state == c_st_resp);
    assign rsp_id    = r_id;
    assign rsp_q     = r_rsp_q;
    assign rsp_r     = r_rsp_r;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_dvz   = r_rsp_dvz;
    assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_arbiter
//  Description : Scoreboard bench for divider_arbiter. Stimulus pushes the
//                expected grants, divider operands and responses; a monitor
//                and a divider stand-in pop and compare as the DUT presents
//                them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

    localparam int N   = 4;
    localparam int W   = 10;
    localparam int IDW = 2;
    localparam int TMO = 64;

    localparam int M_VALID   = 0;
    localparam int M_DVZ     = 1;
    localparam int M_OVF     = 2;
    localparam int M_DVZ_VLD = 3;
    localparam int M_NEVER   = 4;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           ovf;
        logic           dvz;
        logic           tmo;
    } rsp_t;

    logic           clock = 1'b0;
    logic           sclr;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_q;
    logic [W-1:0]   rsp_r;
    logic           rsp_ovf;
    logic           rsp_dvz;
    logic           rsp_tmo;
    logic           busy;
    logic           div_start;
    logic           div_sclr;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic           div_busy;
    logic           div_valid;
    logic           div_ovf;
    logic           div_dvz;
    logic [W-1:0]   div_q;
    logic [W-1:0]   div_r;

    rsp_t         exp_rsp[$];
    logic [N-1:0] exp_gnt[$];
    logic [2*W-1:0] exp_op[$];

    int n_cmp = 0;
    int n_err = 0;
    int m_mode = M_VALID;
    int m_lat  = 2;
    bit m_spur = 1'b0;

    always #5 clock = ~clock;

    divider_arbiter #(
        .N       (N),
        .W       (W),
        .IDW     (IDW),
        .TMO_CYC (TMO)
    ) dut (
        .clock     (clock),
        .sclr      (sclr),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_ovf   (rsp_ovf),
        .rsp_dvz   (rsp_dvz),
        .rsp_tmo   (rsp_tmo),
        .busy      (busy),
        .div_start (div_start),
        .div_sclr  (div_sclr),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_busy  (div_busy),
        .div_valid (div_valid),
        .div_ovf   (div_ovf),
        .div_dvz   (div_dvz),
        .div_q     (div_q),
        .div_r     (div_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: grants and responses ----------------
    always @(negedge clock) begin : mon
        rsp_t         e_r;
        rsp_t         a_r;
        logic [N-1:0] e_g;
        if (rsp_valid) begin
            a_r = {rsp_id, rsp_q, rsp_r, rsp_ovf, rsp_dvz, rsp_tmo};
            if (exp_rsp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %0h expected none", a_r);
            end else begin
                e_r = exp_rsp.pop_front();
                chk("rsp", 64'(a_r), 64'(e_r));
            end
        end
        if (gnt != '0) begin
            if (exp_gnt.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL gnt_unexpected: got %b expected none", gnt);
            end else begin
                e_g = exp_gnt.pop_front();
                chk("gnt_order", 64'(gnt), 64'(e_g));
            end
        end
    end

    // ---------------- divider stand-in ----------------
    initial begin : divm
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] e_op;
        div_busy  = 1'b0;
        div_valid = 1'b0;
        div_ovf   = 1'b0;
        div_dvz   = 1'b0;
        div_q     = '0;
        div_r     = '0;
        forever begin
            @(negedge clock);
            div_valid = m_spur;
            div_q     = m_spur ? 10'h155 : '0;
            if (div_start && !sclr) begin
                if (exp_op.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL op_unexpected: got %0h expected none", {div_a, div_b});
                end else begin
                    e_op = exp_op.pop_front();
                    chk("div_operands", 64'({div_a, div_b}), 64'(e_op));
                end
                a = div_a;
                b = div_b;
                if (m_mode != M_NEVER) begin
                    div_busy = 1'b1;
                    repeat (m_lat) @(negedge clock);
                    div_q     = (b != 0) ? a / b : '1;
                    div_r     = (b != 0) ? a % b : '1;
                    div_valid = (m_mode == M_VALID) || (m_mode == M_DVZ_VLD);
                    div_dvz   = (m_mode == M_DVZ)   || (m_mode == M_DVZ_VLD);
                    div_ovf   = (m_mode == M_OVF);
                    @(negedge clock);
                    div_busy  = 1'b0;
                    div_valid = 1'b0;
                    div_dvz   = 1'b0;
                    div_ovf   = 1'b0;
                    chk("rsp_latency", 64'(rsp_valid), 64'd1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic expect_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_gnt.push_back(N'(1) << i);
        exp_op.push_back({a, b});
    endtask

    task automatic wait_gnt(output logic [N-1:0] g);
        g = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (gnt != '0) begin
                g = gnt;
                break;
            end
        end
        if (g == '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout: got none expected a grant");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy still 1 expected 0");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [N-1:0] g;
        bit           flag;
        sclr  = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_outputs", 64'({gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_ovf, rsp_dvz,
                                   rsp_tmo, busy, div_start, div_a, div_b}), 64'd0);
        chk("reset_div_sclr", 64'(div_sclr), 64'd1);
        sclr = 1'b0;
        @(negedge clock);
        chk("div_sclr_low", 64'(div_sclr), 64'd0);

        // Single request with latency checks: 100/7 = 14 r 2
        m_mode = M_VALID;
        m_lat  = 2;
        set_op(2, 10'd100, 10'd7);
        expect_op(2, 10'd100, 10'd7);
        exp_rsp.push_back('{id: 2'd2, q: 10'd14, r: 10'd2, ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        req[2] = 1'b1;
        @(negedge clock);
        chk("gnt_latency", 64'(gnt), 64'b0100);
        req[2] = 1'b0;
        @(negedge clock);
        chk("start_latency", 64'({gnt, div_start}), 64'b0000_1);
        chk("busy_active", 64'(busy), 64'd1);
        wait_idle();

        // Status pulse while idle must be ignored
        m_spur = 1'b1;
        @(negedge clock);
        m_spur = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_ignores_status", 64'({busy, rsp_valid}), 64'd0);

        // Contention from pointer 0: 0,1,2,3,0
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0;
        m_lat = 3;
        set_op(0, 10'd100,  10'd10);
        set_op(1, 10'd99,   10'd4);
        set_op(2, 10'd1023, 10'd1000);
        set_op(3, 10'd7,    10'd9);
        expect_op(0, 10'd100,  10'd10);
        expect_op(1, 10'd99,   10'd4);
        expect_op(2, 10'd1023, 10'd1000);
        expect_op(3, 10'd7,    10'd9);
        expect_op(0, 10'd100,  10'd10);
        exp_rsp.push_back('{id: 2'd0, q: 10'd10, r: 10'd0,  ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        exp_rsp.push_back('{id: 2'd1, q: 10'd24, r: 10'd3,  ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        exp_rsp.push_back('{id: 2'd2, q: 10'd1,  r: 10'd23, ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        exp_rsp.push_back('{id: 2'd3, q: 10'd0,  r: 10'd7,  ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        exp_rsp.push_back('{id: 2'd0, q: 10'd10, r: 10'd0,  ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_gnt(g);
        req = '0;
        wait_idle();

        // Divide by zero, then dvz together with valid
        set_op(1, 10'd55, 10'd0);
        for (int k = 0; k < 2; k++) begin
            m_mode = (k == 0) ? M_DVZ : M_DVZ_VLD;
            expect_op(1, 10'd55, 10'd0);
            exp_rsp.push_back('{id: 2'd1, q: 10'd0, r: 10'd0, ovf: 1'b0, dvz: 1'b1, tmo: 1'b0});
            req[1] = 1'b1;
            wait_gnt(g);
            req[1] = 1'b0;
            wait_idle();
        end

        // Overflow: 500/3 reported as 166 r 2 with ovf
        m_mode = M_OVF;
        set_op(2, 10'd500, 10'd3);
        expect_op(2, 10'd500, 10'd3);
        exp_rsp.push_back('{id: 2'd2, q: 10'd166, r: 10'd2, ovf: 1'b1, dvz: 1'b0, tmo: 1'b0});
        req[2] = 1'b1;
        wait_gnt(g);
        req[2] = 1'b0;
        flag = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (rsp_valid) begin
                flag = 1'b1;
                break;
            end
        end
        chk("ovf_rsp_seen", 64'(flag), 64'd1);
        @(negedge clock);
        chk("ovf_pulse_end", 64'({rsp_valid, busy}), 64'd0);
        chk("rsp_hold", 64'({rsp_q, rsp_r, rsp_ovf}), 64'({10'd166, 10'd2, 1'b1}));

        // Reset during WAIT drops the operation
        m_mode = M_NEVER;
        set_op(1, 10'd20, 10'd4);
        expect_op(1, 10'd20, 10'd4);
        req[1] = 1'b1;
        wait_gnt(g);
        req[1] = 1'b0;
        repeat (5) @(negedge clock);
        chk("wait_busy", 64'(busy), 64'd1);
        sclr = 1'b1;
        #1;
        chk("mid_reset_div_sclr", 64'(div_sclr), 64'd1);
        @(negedge clock);
        chk("mid_reset_state", 64'({busy, rsp_valid, gnt, div_a, rsp_q}), 64'd0);
        sclr = 1'b0;

        // Pointer back at 0: requester 0 first, then requester 3
        m_mode = M_VALID;
        m_lat  = 1;
        set_op(0, 10'd81,   10'd9);
        set_op(3, 10'd1000, 10'd33);
        expect_op(0, 10'd81,   10'd9);
        expect_op(3, 10'd1000, 10'd33);
        exp_rsp.push_back('{id: 2'd0, q: 10'd9,  r: 10'd0,  ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        exp_rsp.push_back('{id: 2'd3, q: 10'd30, r: 10'd10, ovf: 1'b0, dvz: 1'b0, tmo: 1'b0});
        req = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            wait_gnt(g);
            req = req & ~g;
        end
        wait_idle();

        // Divider never answers
        m_mode = M_NEVER;
        set_op(0, 10'd10, 10'd2);
        expect_op(0, 10'd10, 10'd2);
        req[0] = 1'b1;
        wait_gnt(g);
        req[0] = 1'b0;
        @(negedge clock);   // first WAIT cycle
`ifdef DIV_ARB_WATCHDOG_EN
        exp_rsp.push_back('{id: 2'd0, q: 10'd0, r: 10'd0, ovf: 1'b0, dvz: 1'b0, tmo: 1'b1});
        flag = 1'b0;
        for (int k = 2; k < TMO; k++) begin
            @(negedge clock);
            if (div_sclr) flag = 1'b1;
        end
        chk("wd_no_early_sclr", 64'(flag), 64'd0);
        @(negedge clock);
        chk("wd_sclr_cycle64", 64'(div_sclr), 64'd1);
        @(negedge clock);
        chk("wd_rsp_valid", 64'({rsp_valid, div_sclr}), 64'b10);
        wait_idle();
`else
        flag = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clock);
            if (!busy || div_sclr || rsp_valid) flag = 1'b1;
        end
        chk("no_wd_stays_busy", 64'(flag), 64'd0);
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0;
        @(negedge clock);
`endif

        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
        chk("op_queue_empty",  64'(exp_op.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
